// File: rtl/trena_pkg.sv
// Shared definitions for the distance-meter serial sender: FSM state codes,
// ASCII constants, the 7E1 frame length and the character helpers.
package trena_pkg;

   typedef enum logic [3:0] {
      OCIOSO  = 4'h0,
      CARREGA = 4'h1,
      ENVIA   = 4'h2,
      ESPERA  = 4'h3,
      PROXIMO = 4'h4,
      FIM     = 4'h5
   } estado_t;

   localparam logic [3:0] ESTADO_INVALIDO = 4'hE;

   localparam logic [6:0] ASCII_ZERO      = 7'h30;
   localparam logic [6:0] ASCII_CERQUILHA = 7'h23;
   localparam logic [6:0] ASCII_INTERROG  = 7'h3F;

   localparam int FRAME_BITS = 10;

   // BCD digit to ASCII; a non-decimal code is shown as '?'.
   function automatic logic [6:0] digito_ascii(input logic [3:0] digito);
      if (digito > 4'd9) begin
         return ASCII_INTERROG;
      end else begin
         return ASCII_ZERO + {3'b000, digito};
      end
   endfunction

   // Even parity over the 7 data bits.
   function automatic logic paridade_par(input logic [6:0] dados);
      return ^dados;
   endfunction

endpackage

// File: rtl/tx_serial_7e1.sv
// Asynchronous 7E1 transmitter: start bit, 7 data bits LSB first, even
// parity, stop bit, each bit held CLK_DIV clock cycles. Pulses fim for one
// cycle right after the stop bit ends.
module tx_serial_7e1
   import trena_pkg::*;
#(
   parameter int CLK_DIV = 434
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       partida,
   input  logic [6:0] dados,
   output logic       saida_serial,
   output logic       fim
);

   localparam int TW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [TW-1:0] TIMER_MAX  = TW'(CLK_DIV - 1);
   localparam logic [TW-1:0] TIMER_UM   = TW'(1);
   localparam logic [3:0]    ULTIMO_BIT = 4'(FRAME_BITS - 1);

   logic          r_busy;
   logic          r_saida;
   logic          r_fim;
   logic [TW-1:0] r_timer;
   logic [3:0]    r_bit_cnt;
   logic [8:0]    r_shift;   // bits still to send after the current one

   // Bit timer, bit counter and shift register driving the line.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_busy    <= 1'b0;
         r_saida   <= 1'b1;
         r_fim     <= 1'b0;
         r_timer   <= '0;
         r_bit_cnt <= 4'd0;
         r_shift   <= 9'd0;
      end else begin
         r_fim <= 1'b0;
         if (!r_busy) begin
            r_saida <= 1'b1;
            if (partida) begin
               r_busy    <= 1'b1;
               r_saida   <= 1'b0;
               r_shift   <= {1'b1, paridade_par(dados), dados};
               r_timer   <= '0;
               r_bit_cnt <= 4'd0;
            end
         end else if (r_timer == TIMER_MAX) begin
            r_timer <= '0;
            if (r_bit_cnt == ULTIMO_BIT) begin
               r_busy  <= 1'b0;
               r_saida <= 1'b1;
               r_fim   <= 1'b1;
            end else begin
               r_saida   <= r_shift[0];
               r_shift   <= {1'b0, r_shift[8:1]};
               r_bit_cnt <= r_bit_cnt + 4'd1;
            end
         end else begin
            r_timer <= r_timer + TIMER_UM;
         end
      end
   end

   assign saida_serial = r_saida;
   assign fim          = r_fim;

endmodule

// File: rtl/trena_envio_serial.sv
// Sends a 3-digit BCD distance as the ASCII frame "DDD#" over a 7E1 line.
// The FSM sequences the four characters; bit timing lives in tx_serial_7e1.
module trena_envio_serial
   import trena_pkg::*;
#(
   parameter int         CLK_DIV    = 434,
   parameter logic [6:0] TERMINADOR = 7'h23
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        transmitir,
   input  logic [11:0] medida,
   output logic        saida_serial,
   output logic        ocupado,
   output logic        pronto,
   output logic [3:0]  db_estado
);

   estado_t     r_estado;
   estado_t     w_proximo;
   logic [11:0] r_medida;
   logic [1:0]  r_idx;
   logic        w_partida;
   logic        w_fim;
   logic        w_ocupado;
   logic        w_pronto;
   logic [3:0]  w_db_estado;
   logic [6:0]  w_caractere;

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_estado <= OCIOSO;
      end else begin
         r_estado <= w_proximo;
      end
   end

   // Next-state and state-decoded outputs.
   always_comb begin
      w_proximo   = OCIOSO;
      w_partida   = 1'b0;
      w_ocupado   = 1'b0;
      w_pronto    = 1'b0;
      w_db_estado = ESTADO_INVALIDO;
      case (r_estado)
         OCIOSO: begin
            w_db_estado = OCIOSO;
            if (transmitir) begin
               w_proximo = CARREGA;
            end else begin
               w_proximo = OCIOSO;
            end
         end
         CARREGA: begin
            w_db_estado = CARREGA;
            w_ocupado   = 1'b1;
            w_proximo   = ENVIA;
         end
         ENVIA: begin
            w_db_estado = ENVIA;
            w_ocupado   = 1'b1;
            w_partida   = 1'b1;
            w_proximo   = ESPERA;
         end
         ESPERA: begin
            w_db_estado = ESPERA;
            w_ocupado   = 1'b1;
            if (w_fim) begin
               w_proximo = PROXIMO;
            end else begin
               w_proximo = ESPERA;
            end
         end
         PROXIMO: begin
            w_db_estado = PROXIMO;
            w_ocupado   = 1'b1;
            if (r_idx == 2'd3) begin
               w_proximo = FIM;
            end else begin
               w_proximo = ENVIA;
            end
         end
         FIM: begin
            w_db_estado = FIM;
            w_ocupado   = 1'b1;
            w_pronto    = 1'b1;
            w_proximo   = OCIOSO;
         end
         default: begin
            w_db_estado = ESTADO_INVALIDO;
            w_proximo   = OCIOSO;
         end
      endcase
   end

   // Distance latch and character index; the latch freezes the frame content.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_medida <= 12'd0;
         r_idx    <= 2'd0;
      end else if (r_estado == CARREGA) begin
         r_medida <= medida;
         r_idx    <= 2'd0;
      end else if ((r_estado == PROXIMO) && (r_idx != 2'd3)) begin
         r_idx <= r_idx + 2'd1;
      end
   end

   // Character selected by the index: hundreds, tens, units, terminator.
   always_comb begin
      w_caractere = TERMINADOR;
      case (r_idx)
         2'd0:    w_caractere = digito_ascii(r_medida[11:8]);
         2'd1:    w_caractere = digito_ascii(r_medida[7:4]);
         2'd2:    w_caractere = digito_ascii(r_medida[3:0]);
         2'd3:    w_caractere = TERMINADOR;
         default: w_caractere = TERMINADOR;
      endcase
   end

   tx_serial_7e1 #(
      .CLK_DIV (CLK_DIV)
   ) u_tx (
      .clock        (clock),
      .reset        (reset),
      .partida      (w_partida),
      .dados        (w_caractere),
      .saida_serial (saida_serial),
      .fim          (w_fim)
   );

   assign ocupado   = w_ocupado;
   assign pronto    = w_pronto;
   assign db_estado = w_db_estado;

endmodule
